// File: rtl/keccak_theta_engine.sv
// rtl/keccak_theta_engine.sv - Keccak theta step on a 5x5xLANE_W state, LPC lanes updated per cycle
module keccak_theta_engine #(
    parameter int LANE_W = 4,
    parameter int LPC    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [25*LANE_W-1:0]  in_state,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    output logic [25*LANE_W-1:0]  out_state
);

    if (LPC != 1 && LPC != 5 && LPC != 25) begin : g_lpc_check
        $error("keccak_theta_engine: LPC must be 1, 5 or 25");
    end
    if (LANE_W < 1 || LANE_W > 64) begin : g_lane_w_check
        $error("keccak_theta_engine: LANE_W must be in 1..64");
    end

    typedef enum logic [1:0] {IDLE, LOAD_PAR, APPLY, DONE} state_t;

    localparam logic [5:0] LPC6 = 6'(LPC);
    localparam logic [4:0] LPC5 = 5'(LPC);

    state_t                   state, state_nxt;
    logic [24:0][LANE_W-1:0]  st;
    logic [4:0][LANE_W-1:0]   par;
    logic [4:0][LANE_W-1:0]   par_live;
    logic [4:0][LANE_W-1:0]   delta;
    logic [4:0]               idx;
    logic [5:0]               idx_end;

    assign out_state = st;
    assign idx_end   = {1'b0, idx} + LPC6;

    always_comb begin
        par_live = '0;
        for (int x = 0; x < 5; x++) begin
            par_live[x] = st[x] ^ st[x+5] ^ st[x+10] ^ st[x+15] ^ st[x+20];
        end
    end

    // Per-column correction depends only on x, so one delta lane serves all five rows.
    always_comb begin
        delta = '0;
        for (int x = 0; x < 5; x++) begin
            for (int z = 0; z < LANE_W; z++) begin
                delta[x][z] = par[(x+4)%5][z] ^ par[(x+1)%5][(z+LANE_W-1)%LANE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD_PAR;
            end
            LOAD_PAR: begin
                busy      = 1'b1;
                state_nxt = APPLY;
            end
            APPLY: begin
                busy = 1'b1;
                if (idx_end == 6'd25) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= '0;
            par       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        st        <= in_state;
                        out_valid <= 1'b0;
                    end
                end
                LOAD_PAR: begin
                    par <= par_live;
                    idx <= '0;
                end
                APPLY: begin
                    // Only the registered parity is used, so in-place updates never disturb later lanes.
                    for (int l = 0; l < 25; l++) begin
                        if (6'(l) >= {1'b0, idx} && 6'(l) < idx_end) begin
                            st[l] <= st[l] ^ delta[l%5];
                        end
                    end
                    idx <= idx + LPC5;
                    if (idx_end == 6'd25) out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_theta_engine.sv
// tb/tb_keccak_theta_engine.sv - scoreboard bench for keccak_theta_engine in three configurations
module tb_keccak_theta_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   start_v;
    logic [2:0]   busy_v, done_v, ov_v;
    logic [99:0]  in_v [3];
    logic [99:0]  out0, out1;
    logic [24:0]  out2;

    int           n_chk  = 0;
    int           n_fail = 0;
    int           ndone [3] = '{0, 0, 0};
    int           nv [3] = '{25, 5, 1};
    int           wv [3] = '{4, 4, 1};
    logic [99:0]  exp_q [$];

    always #5 clk = ~clk;

    keccak_theta_engine #(.LANE_W(4), .LPC(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_state(in_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .out_valid(ov_v[0]), .out_state(out0)
    );
    keccak_theta_engine #(.LANE_W(4), .LPC(5)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_state(in_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .out_valid(ov_v[1]), .out_state(out1)
    );
    keccak_theta_engine #(.LANE_W(1), .LPC(25)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_state(in_v[2][24:0]),
        .busy(busy_v[2]), .done(done_v[2]), .out_valid(ov_v[2]), .out_state(out2)
    );

    task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [99:0] get_out(input int i);
        if (i == 0) return out0;
        if (i == 1) return out1;
        return {75'b0, out2};
    endfunction

    function automatic logic [99:0] rnd100();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[99:0];
    endfunction

    function automatic logic [99:0] theta_ref(input logic [99:0] s, input int w);
        logic [99:0] r;
        bit          c [5][4];
        r = '0;
        for (int x = 0; x < 5; x++)
            for (int z = 0; z < 4; z++) begin
                c[x][z] = 1'b0;
                if (z < w)
                    for (int y = 0; y < 5; y++) c[x][z] ^= s[w*(5*y+x)+z];
            end
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                for (int z = 0; z < w; z++)
                    r[w*(5*y+x)+z] = s[w*(5*y+x)+z] ^ c[(x+4)%5][z] ^ c[(x+1)%5][(z+w-1)%w];
        return r;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i]) begin
                ndone[i]++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 100'(1), 100'(0));
                end else begin
                    chk("out_state", get_out(i), exp_q.pop_front());
                    chk("ov_at_done", 100'(ov_v[i]), 100'(1));
                end
            end
        end
    end

    task automatic do_op(input int i, input logic [99:0] s, input logic [99:0] e, input bit spam);
        int got;
        int nd0;
        nd0 = ndone[i];
        @(negedge clk);
        in_v[i]    = s;
        start_v[i] = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start_v[i] = 1'b0;
        in_v[i]    = rnd100();
        chk("busy_load", 100'(busy_v[i]), 100'(1));
        chk("ov_drop", 100'(ov_v[i]), 100'(0));
        got = 0;
        for (int k = 1; k <= 60 && got == 0; k++) begin
            @(negedge clk);
            if (done_v[i]) begin
                got = k;
            end else begin
                start_v[i] = spam && (k <= 10);
                if (spam) in_v[i] = rnd100();
            end
        end
        start_v[i] = 1'b0;
        chk("latency", 100'(got), 100'(nv[i] + 1));
        @(negedge clk);
        chk("done_pulse", 100'(done_v[i]), 100'(0));
        chk("ov_hold", 100'(ov_v[i]), 100'(1));
        chk("busy_idle", 100'(busy_v[i]), 100'(0));
        chk("done_count", 100'(ndone[i] - nd0), 100'(1));
    endtask

    initial begin
        logic [99:0] s, e;
        logic [31:0] r;
        int          nd0;

        rst     = 1'b1;
        start_v = '0;
        for (int i = 0; i < 3; i++) in_v[i] = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_out", get_out(i), 100'(0));
            chk("rst_busy", 100'(busy_v[i]), 100'(0));
            chk("rst_done", 100'(done_v[i]), 100'(0));
            chk("rst_ov", 100'(ov_v[i]), 100'(0));
        end
        rst = 1'b0;

        s = '0; s[0] = 1'b1;
        e = s;
        for (int y = 0; y < 5; y++) begin
            e[4*(5*y+1)]     = 1'b1;
            e[4*(5*y+4) + 1] = 1'b1;
        end
        do_op(0, s, e, 1'b0);

        s = '0; s[71] = 1'b1;
        e = s;
        for (int y = 0; y < 5; y++) begin
            e[4*(5*y+3) + 3] = 1'b1;
            e[4*(5*y+1)]     = 1'b1;
        end
        do_op(0, s, e, 1'b0);

        s = rnd100();
        do_op(0, s, theta_ref(s, 4), 1'b1);
        s = rnd100();
        do_op(0, s, theta_ref(s, 4), 1'b0);

        s = '0;
        for (int x = 0; x < 5; x++) begin
            r = $urandom;
            s[4*x +: 4]     = r[3:0];
            s[4*(5+x) +: 4] = r[3:0];
        end
        do_op(1, s, s, 1'b0);
        for (int t = 0; t < 2; t++) begin
            s = rnd100();
            do_op(1, s, theta_ref(s, 4), 1'b0);
        end

        s = 100'h1FFFFFF;
        do_op(2, s, s, 1'b0);
        for (int t = 0; t < 2; t++) begin
            s = rnd100() & 100'h1FFFFFF;
            do_op(2, s, theta_ref(s, 1), 1'b0);
        end

        s = rnd100();
        @(negedge clk);
        in_v[0]    = s;
        start_v[0] = 1'b1;
        exp_q.push_back(theta_ref(s, 4));
        @(negedge clk);
        start_v[0] = 1'b0;
        nd0 = ndone[0];
        repeat (11) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out", out0, 100'(0));
        chk("abort_busy", 100'(busy_v[0]), 100'(0));
        chk("abort_ov", 100'(ov_v[0]), 100'(0));
        #1 rst = 1'b0;
        void'(exp_q.pop_back());
        repeat (40) @(negedge clk);
        chk("abort_nodone", 100'(ndone[0] - nd0), 100'(0));

        s = rnd100();
        do_op(0, s, theta_ref(s, 4), 1'b0);
        chk("queue_empty", 100'(exp_q.size()), 100'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_theta_engine.md
Name: keccak_theta_engine

Overview:
- Parametrised successor to the single-bit 5x5 column-parity datapath. Applies the Keccak theta step to a full 5x5xLANE_W state: A'[x][y][z] = A[x][y][z] ^ C[(x+4)%5][z] ^ C[(x+1)%5][(z+LANE_W-1)%LANE_W], where C[x][z] is the XOR over y of A[x][y][z].
- Has its own start/busy/done FSM, a parity snapshot register and a configurable number of lanes processed per cycle.
- Sits between state load and rho/pi in the permutation round pipeline.

Parameters:
- LANE_W, 4, bits per lane (1..64); state width is 25*LANE_W.
- LPC, 1, lanes updated per cycle; legal values are 1, 5 and 25 only. Any other value is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to process in_state; sampled only in IDLE.
- in_state  in  25*LANE_W  input state; bit index = LANE_W*(5*y+x)+z.
- busy  out  1  high in states LOAD_PAR and APPLY.
- done  out  1  one-cycle pulse when out_state holds the result.
- out_valid  out  1  high from done until the next accepted start.
- out_state  out  25*LANE_W  working/result state register, same indexing as in_state.

Behaviour:
- Reset (async, any state): FSM=IDLE; state register, parity register, lane index, busy, done and out_valid all 0.
- FSM states: IDLE, LOAD_PAR, APPLY, DONE.
- IDLE:
  - start=1 at a rising edge: capture in_state into the state register, clear out_valid, go to LOAD_PAR.
  - start=0: hold; out_state and out_valid keep their values.
- LOAD_PAR (1 cycle):
  - Register C[x][z] for all x in 0..4, z in 0..LANE_W-1, computed from the unmodified state register.
  - Reset lane index to 0; go to APPLY.
- APPLY (N = 25/LPC cycles):
  - Each cycle, update in place the lanes at linear index L = 5*y+x, for L from idx to idx+LPC-1, using the registered C only (never live parity).
  - Lane order is x inner, y outer. idx increments by LPC per cycle.
  - When idx+LPC = 25: go to DONE and assert done and out_valid on the same edge.
- DONE (1 cycle): done=1, busy=0. Next edge: done=0, go to IDLE.
- start while busy or in DONE is ignored; no queuing.
- Latency: start sampled at edge 0 -> done high in the cycle after edge N+1, i.e. 27 cycles for LPC=1, 7 for LPC=5, 3 for LPC=25.
  - Minimum start-to-start spacing is N+3 cycles.
- Wrap-around:
  - x-1 and x+1 are taken modulo 5.
  - z-1 is taken modulo LANE_W; z=0 takes the parity of z=LANE_W-1.
  - LANE_W=1 reduces to C[x-1] ^ C[x+1] on the single slice.
- in_state may change freely after the start edge; it is not re-sampled.
- rst asserted mid-APPLY aborts the operation. out_state clears to 0 immediately, and no done is produced.
- All arithmetic is XOR only; there is no carry and no width growth.

Test Plan:
- LANE_W=4, LPC=1, only bit (x=0,y=0,z=0) set -> after 27 cycles:
  - bits set at (0,0,0);
  - (1,y,0) for all y;
  - (4,y,1) for all y;
  - 11 ones total; done pulses exactly one cycle.
- LANE_W=1, LPC=25, state all ones -> every C=1, so every element gets 1^1^1 = 1; out_state is all ones. done occurs 3 cycles after start.
- LANE_W=4, LPC=5, every column has even parity (e.g. each lane equal to its y=0 lane, paired so each column XORs to 0) -> out_state == in_state. done at cycle 7.
- Wrap check, LANE_W=4: only bit (2,3,3) set -> bits (3,y,3) and (1,y,0) for all y, plus the original bit.
- Protocol: pulse start again at cycles 1..10 while busy -> ignored, single done. Then start in IDLE -> out_valid drops at that edge and rises with the new done.
- Async rst pulsed mid-APPLY (cycle 12, LPC=1) -> out_state=0, busy=0 and out_valid=0 without waiting for a clock edge. A subsequent start produces a correct result.
